write_bus_arbiter: RTL and testbench

WRITE_BUS_ARBITER -- requirements
Module: write_bus_arbiter

---
 rtl/write_bus_pkg.sv | 9 +
 rtl/write_bus_arbiter_rr_pick.sv | 21 ++
 rtl/write_bus_arbiter.sv | 100 ++++++++++
 tb/tb_write_bus_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/write_bus_pkg.sv
// write_bus_pkg: shared FSM states, requester indices and defaults for write_bus_arbiter
package write_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, OWN, RELEASE} state_t;
  localparam logic [1:0] REQ_FW = 2'd0, REQ_ETH = 2'd1, REQ_RT = 2'd2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return i == REQ_FW ? REQ_ETH : i == REQ_ETH ? REQ_RT : REQ_FW;
  endfunction
endpackage

// File: rtl/write_bus_arbiter_rr_pick.sv
// rr_pick: combinational 3-way round-robin picker starting after last_owner
module rr_pick
  import write_bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] last_owner,
  output logic [1:0] winner,
  output logic       valid
);
  logic [2:0] eff;
  logic [1:0] p0, p1, p2;
  always_comb begin
    eff = req & ~mask;
    p0 = rr_next(last_owner);
    p1 = rr_next(p0);
    p2 = rr_next(p1);
    winner = eff[p0] ? p0 : eff[p1] ? p1 : p2;
    valid = |eff;
  end
endmodule

// File: rtl/write_bus_arbiter.sv
// write_bus_arbiter: round-robin owner of the board register write bus.
// Define WBA_TIMEOUT_EN to bound ownership to TIMEOUT_CYCLES OWN cycles.
module write_bus_arbiter
  import write_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  reg_wen_in,
  input  logic [2:0]  block_wen_in,
  input  logic [2:0]  block_wstart_in,
  input  logic [23:0] reg_waddr_in,
  input  logic [95:0] reg_wdata_in,
  output logic [2:0]  grant,
  output logic        reg_wen,
  output logic        block_wen,
  output logic        block_wstart,
  output logic [7:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic        bus_busy,
  output logic        timeout_err
);
  state_t state;
  logic [1:0] owner, last_owner, winner;
  logic [2:0] mask;
  logic valid, expire;
  if (TIMEOUT_CYCLES < 1) $error("TIMEOUT_CYCLES must be positive");
  rr_pick u_pick (
    .req(req),
    .mask(mask),
    .last_owner(last_owner),
    .winner(winner),
    .valid(valid)
  );
`ifdef WBA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expire = state == OWN && req[owner] && cnt == CW'(TIMEOUT_CYCLES - 1);
  // a timed-out requester stays masked until it lets go of req
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      mask <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= state == OWN ? cnt + 1'b1 : '0;
      mask <= (mask & req) | (expire ? 3'b001 << owner : 3'b000);
      timeout_err <= expire;
    end
`else
  assign expire = 1'b0;
  assign mask = '0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      owner <= REQ_FW;
      last_owner <= REQ_RT;
      grant <= '0;
      reg_wen <= 1'b0;
      block_wen <= 1'b0;
      block_wstart <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      bus_busy <= 1'b0;
    end else
      case (state)
        IDLE: if (valid) begin
          owner <= winner;
          state <= GRANT;
          bus_busy <= 1'b1;
        end
        GRANT: begin
          grant <= 3'b001 << owner;
          state <= OWN;
        end
        OWN: begin
          reg_wen <= reg_wen_in[owner];
          block_wen <= block_wen_in[owner];
          block_wstart <= block_wstart_in[owner];
          reg_waddr <= reg_waddr_in[{owner, 3'd0} +: 8];
          reg_wdata <= reg_wdata_in[{owner, 5'd0} +: 32];
          if (!req[owner] || expire) begin
            grant <= '0;
            last_owner <= owner;
            state <= RELEASE;
          end
        end
        default: begin
          reg_wen <= 1'b0;
          block_wen <= 1'b0;
          block_wstart <= 1'b0;
          bus_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_write_bus_arbiter.sv
// tb_write_bus_arbiter: directed stimulus with a cycle-stamped event scoreboard
module tb_write_bus_arbiter;
  logic clk = 0, reset = 1;
  logic [2:0] req = 0, reg_wen_in = 0, block_wen_in = 0, block_wstart_in = 0;
  logic [23:0] reg_waddr_in = 0;
  logic [95:0] reg_wdata_in = 0;
  logic [2:0] grant;
  logic reg_wen, block_wen, block_wstart, bus_busy, timeout_err;
  logic [7:0] reg_waddr;
  logic [31:0] reg_wdata;
  int cyc = 0, ncmp = 0, nfail = 0;
  typedef struct {
    int cyc; string nm; logic [2:0] g; logic [2:0] s;
    logic [7:0] a; logic [31:0] d; bit dc; logic busy; logic te;
  } ev_t;
  ev_t q[$];
  ev_t e;
  logic [2:0] pg = 0;

  write_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req(req), .reg_wen_in(reg_wen_in),
    .block_wen_in(block_wen_in), .block_wstart_in(block_wstart_in),
    .reg_waddr_in(reg_waddr_in), .reg_wdata_in(reg_wdata_in), .grant(grant),
    .reg_wen(reg_wen), .block_wen(block_wen), .block_wstart(block_wstart),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .bus_busy(bus_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // an event is any grant change, any strobe or a timeout pulse
  always @(negedge clk) begin
    if (grant !== pg || reg_wen || block_wen || block_wstart || timeout_err) begin
      ncmp++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_event: cyc=%0d grant=%b strobes=%b te=%b, required none", cyc, grant,
                 {block_wstart, block_wen, reg_wen}, timeout_err);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || grant !== e.g || {block_wstart, block_wen, reg_wen} !== e.s ||
            bus_busy !== e.busy || timeout_err !== e.te ||
            (!e.dc && (reg_waddr !== e.a || reg_wdata !== e.d))) begin
          nfail++;
          $display("FAIL %s: got cyc=%0d g=%b s=%b a=%h d=%h busy=%b te=%b, required cyc=%0d g=%b s=%b a=%h d=%h busy=%b te=%b",
                   e.nm, cyc, grant, {block_wstart, block_wen, reg_wen}, reg_waddr, reg_wdata, bus_busy,
                   timeout_err, e.cyc, e.g, e.s, e.a, e.d, e.busy, e.te);
        end
      end
    end
    pg = grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic ex(input int c, input string nm, input logic [2:0] g, input logic [2:0] s,
                    input logic [7:0] a, input logic [31:0] d, input bit dc, input logic busy,
                    input logic te);
    q.push_back('{c, nm, g, s, a, d, dc, busy, te});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_strobes", 32'({block_wstart, block_wen, reg_wen}), 0);
    chk("rst_addr", 32'(reg_waddr), 0);
    chk("rst_data", reg_wdata, 0);
    chk("rst_busy", 32'(bus_busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    reset = 0;
    repeat (2) tick();
    // real-time writer alone
    n = cyc;
    reg_waddr_in[23:16] = 8'h10;
    reg_wdata_in[95:64] = 32'h0000_8123;
    req = 3'b100;
    ex(n + 2, "rt_grant", 3'b100, 0, 0, 0, 1, 1, 0);
    ex(n + 3, "rt_reg_wen", 3'b100, 3'b001, 8'h10, 32'h0000_8123, 0, 1, 0);
    ex(n + 4, "rt_release", 3'b000, 0, 8'h10, 32'h0000_8123, 0, 1, 0);
    to(n + 2);
    reg_wen_in = 3'b100;
    tick();
    reg_wen_in = 0;
    req = 0;
    to(n + 6);
    chk("idle_busy", 32'(bus_busy), 0);
    // all three requesting: FW, ETH, RT, FW
    n = cyc;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      ex(n + 2 + 6 * k, "rr_grant", 3'b001 << (k % 3), 0, 0, 0, 1, 1, 0);
      ex(n + 5 + 6 * k, "rr_release", 3'b000, 0, 0, 0, 1, 1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      to(n + 4 + 6 * k);
      req[k % 3] = 1'b0;
      tick();
      req = k == 3 ? 3'b000 : 3'b111;
    end
    to(cyc + 3);
    // ETH owns while FW strobes
    n = cyc;
    reg_waddr_in[15:0] = 16'h2211;
    reg_wdata_in[63:0] = 64'hE0E0_0001_F0F0_0011;
    req = 3'b010;
    ex(n + 2, "eth_grant", 3'b010, 0, 0, 0, 1, 1, 0);
    ex(n + 3, "eth_strobes", 3'b010, 3'b111, 8'h22, 32'hE0E0_0001, 0, 1, 0);
    ex(n + 5, "eth_wstart", 3'b010, 3'b100, 8'h22, 32'hE0E0_0001, 0, 1, 0);
    ex(n + 6, "eth_release", 3'b000, 0, 8'h22, 32'hE0E0_0001, 0, 1, 0);
    to(n + 2);
    reg_wen_in = 3'b011; block_wen_in = 3'b010; block_wstart_in = 3'b011;
    tick();
    reg_wen_in = 3'b001; block_wen_in = 3'b001; block_wstart_in = 3'b001;
    tick();
    block_wstart_in = 3'b010;
    tick();
    block_wstart_in = 3'b001;
    req = 0;
    tick();
    reg_wen_in = 0; block_wen_in = 0; block_wstart_in = 0;
    to(cyc + 3);
    // reset in the middle of FW ownership
    n = cyc;
    req = 3'b001;
    ex(n + 2, "fw_grant", 3'b001, 0, 0, 0, 1, 1, 0);
    ex(n + 3, "fw_block_wen", 3'b001, 3'b010, 8'h11, 32'hF0F0_0011, 0, 1, 0);
    ex(n + 4, "reset_in_own", 3'b000, 0, 8'h00, 32'h0, 0, 0, 0);
    ex(n + 6, "post_rst_fw", 3'b001, 0, 0, 0, 1, 1, 0);
    ex(n + 7, "post_rst_fw_rel", 3'b000, 0, 0, 0, 1, 1, 0);
    ex(n + 10, "post_rst_eth", 3'b010, 0, 0, 0, 1, 1, 0);
    ex(n + 11, "post_rst_eth_rel", 3'b000, 0, 0, 0, 1, 1, 0);
    to(n + 2);
    block_wen_in = 3'b001;
    tick();
    reset = 1;
    tick();
    chk("rst_own_block_wen", 32'(block_wen), 0);
    chk("rst_own_grant", 32'(grant), 0);
    reset = 0;
    block_wen_in = 0;
    req = 3'b011;
    to(n + 6);
    req = 3'b010;
    to(n + 10);
    req = 0;
    to(cyc + 3);
`ifdef WBA_TIMEOUT_EN
    n = cyc;
    req = 3'b010;
    ex(n + 2, "to_grant", 3'b010, 0, 0, 0, 1, 1, 0);
    ex(n + 10, "to_expire", 3'b000, 0, 0, 0, 1, 1, 1);
    ex(n + 23, "to_regrant", 3'b010, 0, 0, 0, 1, 1, 0);
    ex(n + 24, "to_regrant_rel", 3'b000, 0, 0, 0, 1, 1, 0);
    to(n + 20);
    req = 0;
    tick();
    req = 3'b010;
    to(n + 23);
    req = 0;
    to(cyc + 3);
`endif
    chk("queue_drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
